// File: rtl/trig_pkg.sv
// Shared Q16.16 constants, rotator state encoding and quarter-wave angle folding.
package trig_pkg;

    localparam int unsigned FRAC_BITS = 16;
    localparam logic [31:0] Q_ONE     = 32'h0001_0000;

    localparam int unsigned ANGLE_W = 9;
    localparam int unsigned IDX_W   = 7;
    localparam int unsigned LUT_W   = 32;

    localparam logic [ANGLE_W-1:0] DEG_90  = 9'd90;
    localparam logic [ANGLE_W-1:0] DEG_180 = 9'd180;
    localparam logic [ANGLE_W-1:0] DEG_270 = 9'd270;
    localparam logic [ANGLE_W-1:0] DEG_360 = 9'd360;

    typedef enum logic [2:0] {
        IDLE,
        SIN_ADDR,
        SIN_WAIT,
        COS_WAIT,
        MULT,
        SUM,
        DONE
    } rot_state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             neg;
    } fold_t;

    // Map a reduced angle (0..359) onto the first-quadrant table index plus sign.
    function automatic fold_t fold(input logic [ANGLE_W-1:0] a);
        fold_t f;
        f.idx = '0;
        f.neg = 1'b0;
        if (a < DEG_90) begin
            f.idx = IDX_W'(a);
        end else if (a < DEG_180) begin
            f.idx = IDX_W'(DEG_180 - a);
        end else if (a < DEG_270) begin
            f.idx = IDX_W'(a - DEG_180);
            f.neg = 1'b1;
        end else begin
            f.idx = IDX_W'(DEG_360 - a);
            f.neg = 1'b1;
        end
        return f;
    endfunction

    // cos(a) = sin(a + 90), wrapped back into 0..359.
    function automatic logic [ANGLE_W-1:0] cos_angle(input logic [ANGLE_W-1:0] a);
        logic [ANGLE_W-1:0] s;
        s = a + DEG_90;
        return (s >= DEG_360) ? (s - DEG_360) : s;
    endfunction

endpackage

// File: rtl/sine_quarter_lut.sv
// Registered quarter-wave sine table: round(sin(idx deg) * 65536), idx 0..90.
module sine_quarter_lut
    import trig_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in_n,
    input  logic [IDX_W-1:0] idx,
    output logic [LUT_W-1:0] data
);

    // One-cycle table read.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            data <= '0;
        end else begin
            case (idx)
                7'd0:  data <= 32'd0;      7'd1:  data <= 32'd1144;
                7'd2:  data <= 32'd2287;   7'd3:  data <= 32'd3430;
                7'd4:  data <= 32'd4572;   7'd5:  data <= 32'd5712;
                7'd6:  data <= 32'd6850;   7'd7:  data <= 32'd7987;
                7'd8:  data <= 32'd9121;   7'd9:  data <= 32'd10252;
                7'd10: data <= 32'd11380;  7'd11: data <= 32'd12505;
                7'd12: data <= 32'd13626;  7'd13: data <= 32'd14742;
                7'd14: data <= 32'd15855;  7'd15: data <= 32'd16962;
                7'd16: data <= 32'd18064;  7'd17: data <= 32'd19161;
                7'd18: data <= 32'd20252;  7'd19: data <= 32'd21336;
                7'd20: data <= 32'd22415;  7'd21: data <= 32'd23486;
                7'd22: data <= 32'd24550;  7'd23: data <= 32'd25607;
                7'd24: data <= 32'd26656;  7'd25: data <= 32'd27697;
                7'd26: data <= 32'd28729;  7'd27: data <= 32'd29753;
                7'd28: data <= 32'd30767;  7'd29: data <= 32'd31772;
                7'd30: data <= 32'd32768;  7'd31: data <= 32'd33754;
                7'd32: data <= 32'd34729;  7'd33: data <= 32'd35693;
                7'd34: data <= 32'd36647;  7'd35: data <= 32'd37590;
                7'd36: data <= 32'd38521;  7'd37: data <= 32'd39441;
                7'd38: data <= 32'd40348;  7'd39: data <= 32'd41243;
                7'd40: data <= 32'd42126;  7'd41: data <= 32'd42995;
                7'd42: data <= 32'd43852;  7'd43: data <= 32'd44695;
                7'd44: data <= 32'd45525;  7'd45: data <= 32'd46341;
                7'd46: data <= 32'd47143;  7'd47: data <= 32'd47930;
                7'd48: data <= 32'd48703;  7'd49: data <= 32'd49461;
                7'd50: data <= 32'd50203;  7'd51: data <= 32'd50931;
                7'd52: data <= 32'd51643;  7'd53: data <= 32'd52339;
                7'd54: data <= 32'd53020;  7'd55: data <= 32'd53684;
                7'd56: data <= 32'd54332;  7'd57: data <= 32'd54963;
                7'd58: data <= 32'd55578;  7'd59: data <= 32'd56175;
                7'd60: data <= 32'd56756;  7'd61: data <= 32'd57319;
                7'd62: data <= 32'd57865;  7'd63: data <= 32'd58393;
                7'd64: data <= 32'd58903;  7'd65: data <= 32'd59396;
                7'd66: data <= 32'd59870;  7'd67: data <= 32'd60326;
                7'd68: data <= 32'd60764;  7'd69: data <= 32'd61183;
                7'd70: data <= 32'd61584;  7'd71: data <= 32'd61966;
                7'd72: data <= 32'd62328;  7'd73: data <= 32'd62672;
                7'd74: data <= 32'd62997;  7'd75: data <= 32'd63303;
                7'd76: data <= 32'd63589;  7'd77: data <= 32'd63856;
                7'd78: data <= 32'd64104;  7'd79: data <= 32'd64332;
                7'd80: data <= 32'd64540;  7'd81: data <= 32'd64729;
                7'd82: data <= 32'd64898;  7'd83: data <= 32'd65048;
                7'd84: data <= 32'd65177;  7'd85: data <= 32'd65287;
                7'd86: data <= 32'd65376;  7'd87: data <= 32'd65446;
                7'd88: data <= 32'd65496;  7'd89: data <= 32'd65526;
                7'd90: data <= Q_ONE;
                default: data <= '0;
            endcase
        end
    end

endmodule

// File: rtl/point_rotator.sv
// Rotates a signed Q16.16 point by an integer degree angle using one shared sine table.
module point_rotator #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned FRAC_BITS = 16
) (
    input  logic             clk_in,
    input  logic             rst_in_n,
    input  logic [8:0]       angle_in,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic             out_valid,
    input  logic             out_ready
);

    import trig_pkg::*;

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned SW = 2 * WIDTH + 1;

    rot_state_t              state;
    logic signed [WIDTH-1:0] x_r;
    logic signed [WIDTH-1:0] y_r;
    logic signed [WIDTH-1:0] sin_r;
    logic signed [WIDTH-1:0] cos_r;
    logic [ANGLE_W-1:0]      a_r;
    logic                    neg_r;
    logic signed [PW-1:0]    p_xc;
    logic signed [PW-1:0]    p_ys;
    logic signed [PW-1:0]    p_xs;
    logic signed [PW-1:0]    p_yc;

    logic [LUT_W-1:0]        lut_q;
    logic [IDX_W-1:0]        lut_idx_c;
    fold_t                   sin_fold_c;
    fold_t                   cos_fold_c;
    logic [ANGLE_W-1:0]      angle_red_c;
    logic signed [WIDTH-1:0] lut_mag_c;
    logic signed [WIDTH-1:0] lut_signed_c;
    logic signed [SW-1:0]    sum_x_c;
    logic signed [SW-1:0]    sum_y_c;

    sine_quarter_lut u_lut (
        .clk_in   (clk_in),
        .rst_in_n (rst_in_n),
        .idx      (lut_idx_c),
        .data     (lut_q)
    );

    // Table addressing, sign application and final Q16.16 sums.
    always_comb begin
        angle_red_c  = (angle_in >= DEG_360) ? (angle_in - DEG_360) : angle_in;
        sin_fold_c   = fold(a_r);
        cos_fold_c   = fold(cos_angle(a_r));
        lut_idx_c    = '0;
        case (state)
            SIN_ADDR: lut_idx_c = sin_fold_c.idx;
            SIN_WAIT: lut_idx_c = cos_fold_c.idx;
            default:  lut_idx_c = '0;
        endcase
        lut_mag_c    = WIDTH'(lut_q);
        lut_signed_c = neg_r ? -lut_mag_c : lut_mag_c;
        sum_x_c      = SW'(p_xc) - SW'(p_ys);
        sum_y_c      = SW'(p_xs) + SW'(p_yc);
    end

    // Control FSM with its datapath registers and registered handshake outputs.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state     <= IDLE;
            x_r       <= '0;
            y_r       <= '0;
            a_r       <= '0;
            neg_r     <= 1'b0;
            sin_r     <= '0;
            cos_r     <= '0;
            p_xc      <= '0;
            p_ys      <= '0;
            p_xs      <= '0;
            p_yc      <= '0;
            x_out     <= '0;
            y_out     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        x_r      <= x_in;
                        y_r      <= y_in;
                        a_r      <= angle_red_c;
                        in_ready <= 1'b0;
                        state    <= SIN_ADDR;
                    end
                end
                SIN_ADDR: begin
                    neg_r <= sin_fold_c.neg;
                    state <= SIN_WAIT;
                end
                SIN_WAIT: begin
                    sin_r <= lut_signed_c;
                    neg_r <= cos_fold_c.neg;
                    state <= COS_WAIT;
                end
                COS_WAIT: begin
                    cos_r <= lut_signed_c;
                    state <= MULT;
                end
                MULT: begin
                    p_xc  <= PW'(x_r) * PW'(cos_r);
                    p_ys  <= PW'(y_r) * PW'(sin_r);
                    p_xs  <= PW'(x_r) * PW'(sin_r);
                    p_yc  <= PW'(y_r) * PW'(cos_r);
                    state <= SUM;
                end
                SUM: begin
                    x_out     <= WIDTH'(sum_x_c >>> FRAC_BITS);
                    y_out     <= WIDTH'(sum_y_c >>> FRAC_BITS);
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_point_rotator.sv
// Directed plus random transactions checked against a real-valued rotation model.
module tb_point_rotator;

    localparam int unsigned WIDTH = 32;

    logic             clk_in = 1'b0;
    logic             rst_in_n;
    logic [8:0]       angle_in;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] y_in;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x_out;
    logic [WIDTH-1:0] y_out;
    logic             out_valid;
    logic             out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_in = ~clk_in;

    point_rotator #(.WIDTH(WIDTH), .FRAC_BITS(16)) dut (
        .clk_in    (clk_in),
        .rst_in_n  (rst_in_n),
        .angle_in  (angle_in),
        .x_in      (x_in),
        .y_in      (y_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Ideal rotation: trig values rounded to Q16.16, exact products, floor shift, wrap to 32 bits.
    function automatic void model(input int unsigned ang, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] ex, output logic [31:0] ey);
        real    rad, sv, cv;
        longint s, c, xl, yl, rx, ry;
        rad = real'(ang % 360) * 3.141592653589793 / 180.0;
        sv  = $sin(rad) * 65536.0;
        cv  = $cos(rad) * 65536.0;
        s   = longint'($rtoi(sv >= 0.0 ? sv + 0.5 : sv - 0.5));
        c   = longint'($rtoi(cv >= 0.0 ? cv + 0.5 : cv - 0.5));
        xl  = longint'($signed(x));
        yl  = longint'($signed(y));
        rx  = (xl * c - yl * s) >>> 16;
        ry  = (xl * s + yl * c) >>> 16;
        ex  = rx[31:0];
        ey  = ry[31:0];
    endfunction

    task automatic run_txn(input logic [8:0] ang, input logic [31:0] x, input logic [31:0] y, input bit hold);
        logic [31:0] ex, ey;
        int          lat;
        model(int'(ang), x, y, ex, ey);
        @(negedge clk_in);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        angle_in  = ang;
        x_in      = x;
        y_in      = y;
        in_valid  = 1'b1;
        out_ready = !hold;
        @(negedge clk_in);
        in_valid = 1'b0;
        angle_in = 9'($urandom);
        x_in     = $urandom;
        y_in     = $urandom;
        check("in_ready_busy", 64'(in_ready), 64'd0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk_in);
            lat++;
        end
        check($sformatf("latency a=%0d", ang), 64'(lat), 64'd6);
        check($sformatf("x_out a=%0d", ang), 64'(x_out), 64'(ex));
        check($sformatf("y_out a=%0d", ang), 64'(y_out), 64'(ey));
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                in_valid = 1'b1;
                angle_in = 9'($urandom);
                x_in     = $urandom;
                y_in     = $urandom;
                @(negedge clk_in);
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_ready", 64'(in_ready), 64'd0);
                check("hold_x", 64'(x_out), 64'(ex));
                check("hold_y", 64'(y_out), 64'(ey));
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk_in);
        check("release_valid", 64'(out_valid), 64'd0);
        check("release_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        bit saw_valid;
        rst_in_n  = 1'b0;
        angle_in  = '0;
        x_in      = '0;
        y_in      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk_in);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_x_out", 64'(x_out), 64'd0);
        check("rst_y_out", 64'(y_out), 64'd0);
        rst_in_n = 1'b1;

        run_txn(9'd0,   32'h0001_0000, 32'h0002_0000, 1'b0);
        run_txn(9'd90,  32'h0001_0000, 32'h0000_0000, 1'b0);
        run_txn(9'd180, 32'h0001_0000, 32'h0000_8000, 1'b0);
        run_txn(9'd270, 32'h0001_0000, 32'h0000_0000, 1'b0);
        run_txn(9'd30,  32'h0002_0000, 32'h0000_0000, 1'b0);
        run_txn(9'd390, 32'h0002_0000, 32'h0000_0000, 1'b0);
        run_txn(9'd400, 32'h0003_4000, 32'hFFFE_8000, 1'b0);
        run_txn(9'd511, 32'hFFF0_1234, 32'h0007_ABCD, 1'b0);
        run_txn(9'd359, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        run_txn(9'd135, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);

        run_txn(9'd45, 32'h0005_0000, 32'hFFFD_0000, 1'b1);

        @(negedge clk_in);
        angle_in = 9'd45;
        x_in     = 32'h0001_0000;
        y_in     = 32'h0001_0000;
        in_valid = 1'b1;
        @(negedge clk_in);
        in_valid = 1'b0;
        @(negedge clk_in);
        rst_in_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_x_out", 64'(x_out), 64'd0);
        check("midrst_y_out", 64'(y_out), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk_in);
        rst_in_n  = 1'b1;
        saw_valid = 1'b0;
        repeat (8) begin
            @(negedge clk_in);
            if (out_valid) saw_valid = 1'b1;
        end
        check("midrst_no_output", 64'(saw_valid), 64'd0);
        run_txn(9'd0, 32'h0001_0000, 32'h0002_0000, 1'b0);

        for (int i = 0; i < 10; i++) begin
            run_txn(9'($urandom_range(0, 511)), $urandom, $urandom, bit'($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
